mole_position: RTL and testbench



---
 rtl/mole_position.sv | 94 +++++++++
 tb/tb_mole_position.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mole_position.sv
// -----------------------------------------------------------------------------
// mole_position
//
// Pseudo-random hole selector for the whack-a-mole game. Holds the index of
// the hole the mole currently occupies and, on every rising edge of the move
// request, jumps to a new pseudo-random hole that always differs from the
// current one.
//
// A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) free-runs on every
// non-reset clock; its low three bits are folded into 0..NUM_HOLES-1 to form
// the candidate hole.
//
// Parameters
//   NUM_HOLES  number of valid holes, 4..8
//   LFSR_SEED  LFSR reset value (all-zero is replaced by 16'h0001)
//
// Ports
//   i_clk              system clock, rising edge
//   i_rst              synchronous active-high reset
//   i_change_position  move request (level, edge-detected internally)
//   o_mole_position    current hole index, registered
//   o_moved            one-cycle strobe following a position update
// -----------------------------------------------------------------------------
module mole_position #(
   parameter int          NUM_HOLES = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_change_position,
   output logic [2:0] o_mole_position,
   output logic       o_moved
);

   // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [3:0]  NH   = 4'(NUM_HOLES);

   logic [15:0] lfsr_q, lfsr_d;
   logic        change_q;
   logic [2:0]  pos_q, pos_d;
   logic        moved_q, moved_d;
   logic        req;
   logic        fb;
   logic [2:0]  cand;

   // Fold a 3-bit raw value into 0..NUM_HOLES-1 and bump it past the current
   // hole. With NUM_HOLES >= 4 a single subtraction is enough for raw <= 7.
   function automatic logic [2:0] pick_hole(input logic [2:0] raw,
                                            input logic [2:0] cur);
      logic [3:0] c;
      c = {1'b0, raw};
      if (c >= NH) begin
         c = c - NH;
      end
      if (c[2:0] == cur) begin
         c = ((c + 4'd1) == NH) ? 4'd0 : (c + 4'd1);
      end
      return c[2:0];
   endfunction

   assign fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign req  = i_change_position & ~change_q;
   assign cand = pick_hole(lfsr_q[2:0], pos_q);

   always_comb begin
      lfsr_d  = {lfsr_q[14:0], fb};
      pos_d   = pos_q;
      moved_d = 1'b0;
      if (req) begin
         pos_d   = cand;
         moved_d = 1'b1;
      end
   end

   // Reset wins over a coincident request, so the sequence restarts cleanly.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lfsr_q   <= SEED;
         change_q <= 1'b0;
         pos_q    <= 3'd0;
         moved_q  <= 1'b0;
      end else begin
         lfsr_q   <= lfsr_d;
         change_q <= i_change_position;
         pos_q    <= pos_d;
         moved_q  <= moved_d;
      end
   end

   assign o_mole_position = pos_q;
   assign o_moved         = moved_q;

endmodule

// File: tb/tb_mole_position.sv
// -----------------------------------------------------------------------------
// tb_mole_position
//
// Self-checking bench for mole_position. Two instances share clock and reset:
// one with 8 holes, one with 5. Expected positions come from a reference model
// that replays the LFSR from the seed for the number of non-reset clocks seen
// so far and folds the value into the hole range with modulo arithmetic.
// -----------------------------------------------------------------------------
module tb_mole_position;

   logic       clk = 1'b0;
   logic       rst;
   logic       chg8, chg5;
   logic [2:0] pos8, pos5;
   logic       mv8, mv5;

   int n_checks = 0;
   int n_fail   = 0;
   int n_edges  = 0;   // non-reset rising edges since last reset
   int prev8    = 0;
   int prev5    = 0;
   int first_k  = 0;
   int first_pos = 0;
   bit [7:0] hits8 = '0;

   always #5 clk = ~clk;

   mole_position #(.NUM_HOLES(8), .LFSR_SEED(16'hACE1)) dut8 (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_change_position (chg8),
      .o_mole_position   (pos8),
      .o_moved           (mv8)
   );

   mole_position #(.NUM_HOLES(5), .LFSR_SEED(16'hACE1)) dut5 (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_change_position (chg5),
      .o_mole_position   (pos5),
      .o_moved           (mv5)
   );

   always @(posedge clk) begin
      if (rst) n_edges <= 0;
      else     n_edges <= n_edges + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // LFSR value after k steps from the seed; taps 15,13,12,10 as a parity mask.
   function automatic int model_pos(input int k, input int prev, input int nh);
      logic [15:0] v;
      int raw, c;
      v = 16'hACE1;
      for (int i = 0; i < k; i++) v = {v[14:0], ^(v & 16'hB400)};
      raw = int'(v) % 8;
      c = raw % nh;
      if (c == prev) c = (c + 1) % nh;
      return c;
   endfunction

   // One-cycle request pulse on the chosen instance, checked on the next cycle.
   task automatic do_pulse(input bit use5, input string tag, output int got);
      int k, nh, e, prev;
      k    = n_edges;
      nh   = use5 ? 5 : 8;
      prev = use5 ? prev5 : prev8;
      if (use5) chg5 = 1'b1; else chg8 = 1'b1;
      tick();
      chg8 = 1'b0;
      chg5 = 1'b0;
      got = use5 ? int'(pos5) : int'(pos8);
      e = model_pos(k, prev, nh);
      check({tag, " pos"}, got, e);
      check({tag, " moved"}, use5 ? int'(mv5) : int'(mv8), 1);
      check({tag, " range"}, int'(got < nh), 1);
      check({tag, " distinct"}, int'(got != prev), 1);
      if (use5) prev5 = got;
      else begin
         prev8 = got;
         hits8[got[2:0]] = 1'b1;
      end
      tick();
      check({tag, " moved_off"}, use5 ? int'(mv5) : int'(mv8), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int got, moves, strobes, last;

      // Reset and idle
      rst = 1'b1; chg8 = 1'b0; chg5 = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("reset pos8", int'(pos8), 0);
      check("reset moved8", int'(mv8), 0);
      check("reset pos5", int'(pos5), 0);
      check("reset moved5", int'(mv5), 0);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle pos8", int'(pos8), 0);
         check("idle moved8", int'(mv8), 0);
      end

      // First move after reset
      first_k = n_edges;
      do_pulse(1'b0, "first", got);
      first_pos = got;
      check("first nonzero", int'(first_pos != 0), 1);

      // Level held high: exactly one move
      last = prev8;
      got = model_pos(n_edges, prev8, 8);
      chg8 = 1'b1;
      tick();
      check("hold pos", int'(pos8), got);
      moves = 0; strobes = 0;
      if (int'(pos8) != last) moves++;
      if (mv8) strobes++;
      last = int'(pos8);
      for (int i = 0; i < 9; i++) begin
         tick();
         if (int'(pos8) != last) moves++;
         if (mv8) strobes++;
         last = int'(pos8);
      end
      chg8 = 1'b0;
      tick();
      if (mv8) strobes++;
      check("hold moves", moves, 1);
      check("hold strobes", strobes, 1);
      prev8 = int'(pos8);

      // 200 moves on the 8-hole instance with random gaps
      for (int i = 0; i < 200; i++) begin
         do_pulse(1'b0, "seq8", got);
         repeat ($urandom_range(0, 2)) tick();
      end
      check("all holes hit", int'(hits8), 8'hFF);

      // 100 moves on the 5-hole instance
      for (int i = 0; i < 100; i++) begin
         do_pulse(1'b1, "seq5", got);
         repeat ($urandom_range(0, 2)) tick();
      end

      // Reset coinciding with a request
      chg8 = 1'b1;
      rst  = 1'b1;
      tick();
      rst  = 1'b0;
      chg8 = 1'b0;
      check("rst+req pos", int'(pos8), 0);
      check("rst+req moved", int'(mv8), 0);
      prev8 = 0;
      prev5 = 0;
      while (n_edges < first_k) begin
         tick();
         check("post-rst idle moved", int'(mv8), 0);
      end
      do_pulse(1'b0, "replay", got);
      check("replay matches first", got, first_pos);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
